// File: rtl/fetch_sequencer.sv
// fetch_sequencer: machine-cycle fetch sequencer. Latches OPR/OPA, sequences
// two-word fetches and issues PC-load, stack push/pop and immediate-select.
// Ports: clk, rst (sync, active-high); cycle/romData/pcAddr/ccOut/iszNonZero in;
// opr, opa, imm8, secondWord, execEn, useImm, pcLoad, pcNew, stackPush,
// stackPop, instrDone out.
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cycle,
  input  logic [3:0]  romData,
  input  logic [11:0] pcAddr,
  input  logic        ccOut,
  input  logic        iszNonZero,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [7:0]  imm8,
  output logic        secondWord,
  output logic        execEn,
  output logic        useImm,
  output logic        pcLoad,
  output logic [11:0] pcNew,
  output logic        stackPush,
  output logic        stackPop,
  output logic        instrDone
);

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    WORD1     = 2'd1,
    WORD2     = 2'd2
  } state_t;

  localparam logic [3:0] OP_JCN = 4'b0001;
  localparam logic [3:0] OP_FIM = 4'b0010;
  localparam logic [3:0] OP_JUN = 4'b0100;
  localparam logic [3:0] OP_JMS = 4'b0101;
  localparam logic [3:0] OP_ISZ = 4'b0111;
  localparam logic [3:0] OP_BBL = 4'b1100;
  localparam logic [3:0] OP_LDM = 4'b1101;

  state_t      state_q;
  logic [3:0]  opr_q;
  logic [3:0]  opa_q;
  logic [7:0]  imm8_q;
  logic [3:0]  page_q;
  logic [11:0] pcnew_q;
  logic        pcload_q;
  logic        push_q;
  logic        pop_q;
  logic        done_q;
  logic [2:0]  prev_q;

  logic        two_word;
  logic        final_word;
  logic        retire;
  logic        oos;
  logic        act_load;
  logic        act_push;
  logic        act_pop;
  logic [11:0] act_target;
  logic        unused_pc;

  // Only the page nibble of the PC is needed.
  assign unused_pc = ^pcAddr[7:0];

  always_comb begin
    two_word = (opr_q == OP_JCN) || (opr_q == OP_JUN) ||
               (opr_q == OP_JMS) || (opr_q == OP_ISZ) ||
               ((opr_q == OP_FIM) && !opa_q[0]);
  end

  // The word whose execute window retires the instruction.
  assign final_word = (state_q == WORD2) ||
                      ((state_q == WORD1) && !two_word);
  assign retire     = final_word && (cycle == 3'd7);

  // A cycle 0 not preceded by cycle 7 means the generator restarted.
  assign oos = (cycle == 3'd0) && (prev_q != 3'd7);

  always_comb begin
    act_load   = 1'b0;
    act_push   = 1'b0;
    act_pop    = 1'b0;
    act_target = {opa_q, imm8_q};
    case (opr_q)
      OP_JUN: act_load = 1'b1;
      OP_JMS: begin
        act_load = 1'b1;
        act_push = 1'b1;
      end
      OP_JCN: begin
        act_load   = ccOut;
        act_target = {page_q, imm8_q};
      end
      OP_ISZ: begin
        act_load   = iszNonZero;
        act_target = {page_q, imm8_q};
      end
      OP_BBL: act_pop = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC_WAIT;
      opr_q    <= 4'h0;
      opa_q    <= 4'h0;
      imm8_q   <= 8'h00;
      page_q   <= 4'h0;
      pcnew_q  <= 12'h000;
      pcload_q <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      done_q   <= 1'b0;
      prev_q   <= 3'd0;
    end else begin
      pcload_q <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      done_q   <= 1'b0;
      prev_q   <= cycle;
      case (state_q)
        SYNC_WAIT: begin
          if (cycle == 3'd0) state_q <= WORD1;
        end
        WORD1: begin
          if (oos) begin
            state_q <= SYNC_WAIT;
          end else begin
            if (cycle == 3'd3) opr_q <= romData;
            if (cycle == 3'd4) opa_q <= romData;
            if ((cycle == 3'd7) && two_word) state_q <= WORD2;
          end
        end
        WORD2: begin
          if (oos) begin
            state_q <= SYNC_WAIT;
          end else begin
            if (cycle == 3'd3) begin
              imm8_q[7:4] <= romData;
              page_q      <= pcAddr[11:8];
            end
            if (cycle == 3'd4) imm8_q[3:0] <= romData;
            if (cycle == 3'd7) state_q <= WORD1;
          end
        end
        default: state_q <= SYNC_WAIT;
      endcase
      if (retire) begin
        done_q   <= 1'b1;
        pcload_q <= act_load;
        push_q   <= act_push;
        pop_q    <= act_pop;
        if (act_load) pcnew_q <= act_target;
      end
    end
  end

  assign opr        = opr_q;
  assign opa        = opa_q;
  assign imm8       = imm8_q;
  assign pcNew      = pcnew_q;
  assign pcLoad     = pcload_q;
  assign stackPush  = push_q;
  assign stackPop   = pop_q;
  assign instrDone  = done_q;
  assign secondWord = (state_q == WORD2);
  assign execEn     = final_word && (cycle >= 3'd5);
  assign useImm     = execEn &&
                      ((opr_q == OP_LDM) || (opr_q == OP_BBL));

endmodule
